// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak rho/pi lane engine.
// Holds the lane count, the rho rotation-offset table, the pi destination
// mapping and the engine FSM state type.
package keccak_pkg;

    localparam int unsigned NUM_LANES = 25;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StFinish
    } rp_state_e;

    // Rho offset for lane index x + 5*y. Rows below are y = 0..4, columns x = 0..4.
    function automatic logic [5:0] rho_offset(input logic [4:0] lane);
        logic [5:0] r;
        case (lane)
            5'd0:  r = 6'd0;
            5'd1:  r = 6'd1;
            5'd2:  r = 6'd62;
            5'd3:  r = 6'd28;
            5'd4:  r = 6'd27;
            5'd5:  r = 6'd36;
            5'd6:  r = 6'd44;
            5'd7:  r = 6'd6;
            5'd8:  r = 6'd55;
            5'd9:  r = 6'd20;
            5'd10: r = 6'd3;
            5'd11: r = 6'd10;
            5'd12: r = 6'd43;
            5'd13: r = 6'd25;
            5'd14: r = 6'd39;
            5'd15: r = 6'd41;
            5'd16: r = 6'd45;
            5'd17: r = 6'd15;
            5'd18: r = 6'd21;
            5'd19: r = 6'd8;
            5'd20: r = 6'd18;
            5'd21: r = 6'd2;
            5'd22: r = 6'd61;
            5'd23: r = 6'd56;
            5'd24: r = 6'd14;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Pi moves lane (x, y) to (y, 2x + 3y mod 5); returns the destination lane index.
    function automatic logic [4:0] pi_dest(input logic [4:0] lane);
        int unsigned li;
        int unsigned x;
        int unsigned y;
        int unsigned d;
        li = 32'(lane);
        x  = li % 5;
        y  = li / 5;
        d  = y + 5 * ((2 * x + 3 * y) % 5);
        return 5'(d);
    endfunction

endpackage

// File: rtl/rho_rotator.sv
// Combinational left rotator for one Keccak lane.
// Ports:
//   data    - lane value, bit 0 = LSB
//   amount  - rotation amount, taken mod LANE_W
//   rotated - data rotated left, out[(i + amount) mod LANE_W] = data[i]
module rho_rotator #(
    parameter int unsigned LANE_W = 64
) (
    input  logic [LANE_W-1:0] data,
    input  logic [5:0]        amount,
    output logic [LANE_W-1:0] rotated
);

    logic [31:0] amt_mod;

    assign amt_mod = 32'(amount) % LANE_W;

    // A right shift by LANE_W yields zero, so amount 0 returns data unchanged.
    assign rotated = (data << amt_mod) | (data >> (LANE_W - amt_mod));

endmodule

// File: rtl/rho_pi_engine.sv
// Keccak rho (optionally rho+pi) engine over a 25-lane state held in external memory.
// One pass reads each lane from the source bank, rotates it by its rho offset and
// writes it back in place (pi_en = 0) or to its pi position in the destination bank.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   start, pi_en       - pass request and mode, sampled together in idle only
//   mem_rdata          - read data, valid RD_LAT cycles after the mem_r cycle
//   mem_addr           - {bank, lane}; bank 0 = source, 1 = destination
//   mem_wdata          - write data, valid while mem_w = 1
//   mem_r, mem_w       - one-cycle read / write strobes per lane
//   busy, done         - pass in progress / one-cycle completion pulse
module rho_pi_engine
    import keccak_pkg::*;
#(
    parameter int unsigned LANE_W = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pi_en,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic [5:0]        mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              mem_r,
    output logic              mem_w,
    output logic              busy,
    output logic              done
);

    rp_state_e         state_q, state_d;
    logic [4:0]        lane_q, lane_d;
    logic              pi_q, pi_d;
    logic [1:0]        wait_q, wait_d;
    logic [LANE_W-1:0] data_q, data_d;
    logic [LANE_W-1:0] rot_data;

    rho_rotator #(
        .LANE_W (LANE_W)
    ) u_rotator (
        .data    (data_q),
        .amount  (rho_offset(lane_q)),
        .rotated (rot_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            lane_q  <= '0;
            pi_q    <= 1'b0;
            wait_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pi_q    <= pi_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        pi_d    = pi_q;
        wait_d  = wait_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                // Mode is latched here so pi_en is ignored for the rest of the pass.
                if (start) begin
                    state_d = StRead;
                    lane_d  = '0;
                    pi_d    = pi_en;
                end
            end
            StRead: begin
                state_d = StWait;
                wait_d  = '0;
            end
            StWait: begin
                // Read data lands in the last wait cycle; capture it on the way out.
                if (wait_q == 2'(RD_LAT - 1)) begin
                    state_d = StWrite;
                    data_d  = mem_rdata;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StWrite: begin
                if (lane_q == 5'(NUM_LANES - 1)) begin
                    state_d = StFinish;
                end else begin
                    lane_d  = lane_q + 5'd1;
                    state_d = StRead;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode the state register directly, so an asynchronous reset
    // clears them in the same cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StFinish);
        case (state_q)
            StRead: begin
                mem_r    = 1'b1;
                mem_addr = {1'b0, lane_q};
            end
            StWrite: begin
                mem_w     = 1'b1;
                mem_wdata = rot_data;
                mem_addr  = pi_q ? {1'b1, pi_dest(lane_q)} : {1'b0, lane_q};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rho_pi_engine.sv
// Self-checking bench for rho_pi_engine: a 64-bit / RD_LAT=1 instance and an
// 8-bit / RD_LAT=2 instance run side by side against behavioural memories.
// Expected writes are queued when a pass starts and popped as writes appear.
module tb_rho_pi_engine;

    typedef struct {
        logic [5:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        pi_en;

    logic [63:0] rdata64, wdata64;
    logic [5:0]  addr64;
    logic        r64, w64, busy64, done64;
    logic [7:0]  rdata8, wdata8;
    logic [5:0]  addr8;
    logic        r8, w8, busy8, done8;

    always #5 clock = ~clock;

    rho_pi_engine #(.LANE_W(64), .RD_LAT(1)) dut64 (
        .clock(clock), .reset(reset), .start(start), .pi_en(pi_en),
        .mem_rdata(rdata64), .mem_addr(addr64), .mem_wdata(wdata64),
        .mem_r(r64), .mem_w(w64), .busy(busy64), .done(done64)
    );

    rho_pi_engine #(.LANE_W(8), .RD_LAT(2)) dut8 (
        .clock(clock), .reset(reset), .start(start), .pi_en(pi_en),
        .mem_rdata(rdata8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_r(r8), .mem_w(w8), .busy(busy8), .done(done8)
    );

    // Behavioural memories with the read latency each instance expects.
    logic [63:0] mem64 [64];
    logic [7:0]  mem8  [64];
    logic [63:0] rd64_s1;
    logic [7:0]  rd8_s1, rd8_s2;

    always @(posedge clock) begin
        if (r64) rd64_s1 <= mem64[addr64];
        if (w64) mem64[addr64] <= wdata64;
        if (r8) rd8_s1 <= mem8[addr8];
        rd8_s2 <= rd8_s1;
        if (w8) mem8[addr8] <= wdata8;
    end

    assign rdata64 = rd64_s1;
    assign rdata8  = rd8_s2;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Rotation offsets indexed [y][x].
    int r_tab [5][5] = '{
        '{0, 1, 62, 28, 27},
        '{36, 44, 6, 55, 20},
        '{3, 10, 43, 25, 39},
        '{41, 45, 15, 21, 8},
        '{18, 2, 61, 56, 14}
    };

    function automatic logic [63:0] rotl(input logic [63:0] v, input int sh, input int w);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) o = o | (64'd1 << ((i + sh) % w));
        end
        return o;
    endfunction

    wr_t q64[$];
    wr_t q8[$];
    bit  pi_mode = 1'b0;
    int  n_r64, n_w64, n_r8, n_w8, n_coinc, n_srcw;

    task automatic push_expected(input logic pi);
        for (int l = 0; l < 25; l++) begin
            int  x;
            int  y;
            int  d;
            wr_t e;
            x = l % 5;
            y = l / 5;
            d = pi ? 32 + y + 5 * ((2 * x + 3 * y) % 5) : l;
            e.addr = 6'(d);
            e.data = rotl(mem64[l], r_tab[y][x] % 64, 64);
            q64.push_back(e);
            e.data = rotl({56'd0, mem8[l]}, r_tab[y][x] % 8, 8);
            q8.push_back(e);
        end
    endtask

    task automatic clear_counts();
        n_r64 = 0; n_w64 = 0; n_r8 = 0; n_w8 = 0; n_coinc = 0; n_srcw = 0;
    endtask

    // Write monitor / scoreboard consumer.
    initial begin
        wr_t em;
        forever begin
            @(negedge clock);
            if (r64) n_r64++;
            if (r8) n_r8++;
            if ((r64 && w64) || (r8 && w8)) n_coinc++;
            if (pi_mode && ((w64 && !addr64[5]) || (w8 && !addr8[5]))) n_srcw++;
            if (w64) begin
                n_w64++;
                if (q64.size() == 0) check_val("sb64_unexpected_write", 64'd1, 64'd0);
                else begin
                    em = q64.pop_front();
                    check_val("wr64_addr", 64'(addr64), 64'(em.addr));
                    check_val("wr64_data", wdata64, em.data);
                end
            end
            if (w8) begin
                n_w8++;
                if (q8.size() == 0) check_val("sb8_unexpected_write", 64'd1, 64'd0);
                else begin
                    em = q8.pop_front();
                    check_val("wr8_addr", 64'(addr8), 64'(em.addr));
                    check_val("wr8_data", 64'(wdata8), em.data);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctrl64"}, 64'({busy64, done64, r64, w64}), 64'd0);
        check_val({tag, "_addr64"}, 64'(addr64), 64'd0);
        check_val({tag, "_wdata64"}, wdata64, 64'd0);
        check_val({tag, "_ctrl8"}, 64'({busy8, done8, r8, w8}), 64'd0);
        check_val({tag, "_addr8"}, 64'(addr8), 64'd0);
        check_val({tag, "_wdata8"}, 64'(wdata8), 64'd0);
    endtask

    // One full pass. Start is raised in relative cycle 0; optional second start
    // at cycle 10, or start held high until the cycle after done.
    task automatic run_pass(input logic pi, input bit restart_pulse, input bit hold);
        int d64 = -1;
        int d8 = -1;
        int b_first = -1;
        int b_cnt = 0;
        clear_counts();
        @(negedge clock);
        push_expected(pi);
        pi_mode = pi;
        start = 1'b1;
        pi_en = pi;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            if (k == 1) begin
                pi_en = ~pi;
                if (!hold) start = 1'b0;
            end
            if (restart_pulse && k == 10) start = 1'b1;
            if (restart_pulse && k == 11) start = 1'b0;
            if (busy64) begin
                if (b_first < 0) b_first = k;
                b_cnt++;
            end
            if (d64 >= 0 && k == d64 + 1) begin
                if (hold) begin
                    check_val("idle_after_finish_busy", 64'(busy64), 64'd0);
                    start = 1'b0;
                end
            end
            if (done64 && d64 < 0) d64 = k;
            if (done8 && d8 < 0) d8 = k;
            if (d64 >= 0 && d8 >= 0 && k > d64 + 2 && k > d8 + 2) break;
        end
        start = 1'b0;
        check_val("done64_cycle", 64'(d64), 64'd76);
        check_val("done8_cycle", 64'(d8), 64'd101);
        check_val("busy64_first", 64'(b_first), 64'd1);
        check_val("busy64_cycles", 64'(b_cnt), 64'd76);
        check_val("reads64", 64'(n_r64), 64'd25);
        check_val("writes64", 64'(n_w64), 64'd25);
        check_val("reads8", 64'(n_r8), 64'd25);
        check_val("writes8", 64'(n_w8), 64'd25);
        check_val("rw_coincident", 64'(n_coinc), 64'd0);
        check_val("sb64_left", 64'(q64.size()), 64'd0);
        check_val("sb8_left", 64'(q8.size()), 64'd0);
        if (pi) check_val("src_bank_writes", 64'(n_srcw), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pi_en = 1'b0;
        for (int l = 0; l < 64; l++) begin
            mem64[l] = {$urandom, $urandom};
            mem8[l]  = 8'($urandom);
        end
        mem64[0] = 64'h0123_4567_89AB_CDEF;
        mem64[1] = 64'h1;
        mem64[2] = 64'h4;
        mem8[2]  = 8'h01;
        mem8[6]  = 8'h0F;

        repeat (3) @(posedge clock);
        #1 check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // In-place rho with an ignored second start at cycle 10.
        run_pass(1'b0, 1'b1, 1'b0);
        check_val("lane0_unchanged", mem64[0], 64'h0123_4567_89AB_CDEF);
        check_val("lane1_rot1", mem64[1], 64'h2);
        check_val("lane2_rot62", mem64[2], 64'h1);
        check_val("w8_lane2_rot6", 64'(mem8[2]), 64'h40);
        check_val("w8_lane6_rot4", 64'(mem8[6]), 64'hF0);

        // Rho+pi with start held high through finish.
        mem64[1] = 64'hA5;
        run_pass(1'b1, 1'b0, 1'b1);
        check_val("pi_lane1_dest42", mem64[42], 64'h14A);
        repeat (5) @(negedge clock);
        check_val("no_restart_busy64", 64'(busy64), 64'd0);

        // Reset in the middle of a pass.
        clear_counts();
        @(negedge clock);
        push_expected(1'b0);
        pi_mode = 1'b0;
        start = 1'b1;
        pi_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        reset = 1'b1;
        #1 check_all_zero("mid_reset");
        q64.delete();
        q8.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_counts();
        repeat (12) @(negedge clock);
        check_val("no_strobes_after_reset", 64'(n_r64 + n_w64 + n_r8 + n_w8), 64'd0);
        check_val("idle_after_reset", 64'({busy64, busy8, done64, done8}), 64'd0);

        // Fresh pass after the abort.
        run_pass(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
